// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage feeding the decoder through the IF/ID register.
//   Owns the PC, keeps at most one request outstanding to a variable-latency
//   instruction memory, parks a returned word in a one-entry hold buffer while
//   decode is stalled, and flushes wrong-path work on a taken branch/JAL.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   stall        decode stall: hold IF/ID and do not advance the PC
//   redirect     taken branch/JAL from execute
//   redirect_pc  redirect target byte address (low two bits ignored)
//   imem_req     one-cycle request strobe to instruction memory
//   imem_addr    word-aligned request address (always the current PC)
//   imem_rvalid  response valid (only meaningful while waiting)
//   imem_rdata   response instruction word
//   ifid_valid   IF/ID holds a real instruction
//   ifid_pc      PC of the IF/ID instruction
//   ifid_instr   IF/ID instruction (NOP when empty)
//   ifid_opcode  ifid_instr[6:0], feeds the decoder opcode input
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             ifid_valid,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [INS_W-1:0] ifid_instr,
    output logic [6:0]       ifid_opcode
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [INS_W-1:0] NOP        = INS_W'(32'h0000_0013);
    localparam logic [PC_W-1:0]  PC_STEP    = PC_W'(32'd4);
    localparam logic [PC_W-1:0]  ALIGN_MASK = ~(PC_W'(32'd3));

    state_t             state_r;
    logic [PC_W-1:0]    pc_r;
    logic               kill_r;
    logic [INS_W-1:0]   hold_buf_r;
    logic               req_r;
    logic               ifid_valid_r;
    logic [PC_W-1:0]    ifid_pc_r;
    logic [INS_W-1:0]   ifid_instr_r;

    logic [PC_W-1:0]    target_s;
    logic               deliver_s;
    logic [INS_W-1:0]   deliver_instr_s;

    assign target_s    = redirect_pc & ALIGN_MASK;

    assign imem_req    = req_r;
    assign imem_addr   = pc_r & ALIGN_MASK;
    assign ifid_valid  = ifid_valid_r;
    assign ifid_pc     = ifid_pc_r;
    assign ifid_instr  = ifid_instr_r;
    assign ifid_opcode = ifid_instr_r[6:0];

    // Decide whether an instruction reaches IF/ID this cycle and from where.
    // A killed (wrong-path) response is never delivered; redirect or stall
    // block delivery, the stalled word having been parked in hold_buf_r.
    always_comb begin
        deliver_s       = 1'b0;
        deliver_instr_s = hold_buf_r;
        if (redirect || stall) begin
            deliver_s       = 1'b0;
            deliver_instr_s = hold_buf_r;
        end else if ((state_r == ST_WAIT) && imem_rvalid && !kill_r) begin
            deliver_s       = 1'b1;
            deliver_instr_s = imem_rdata;
        end else if (state_r == ST_HOLD) begin
            deliver_s       = 1'b1;
            deliver_instr_s = hold_buf_r;
        end else begin
            deliver_s       = 1'b0;
            deliver_instr_s = hold_buf_r;
        end
    end

    // Fetch FSM: PC, kill flag, hold buffer and the registered request strobe.
    // req_r is set on every transition into ST_REQ so it is high exactly there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            kill_r     <= 1'b0;
            hold_buf_r <= {INS_W{1'b0}};
            req_r      <= 1'b0;
        end else begin
            req_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_REQ;
                    req_r   <= 1'b1;
                    if (redirect) begin
                        pc_r <= target_s;
                    end
                end
                ST_REQ: begin
                    state_r <= ST_WAIT;
                    // The request just issued is now wrong-path; drop its reply.
                    if (redirect) begin
                        pc_r   <= target_s;
                        kill_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_r || redirect) begin
                            kill_r  <= 1'b0;
                            state_r <= ST_REQ;
                            req_r   <= 1'b1;
                            if (redirect) begin
                                pc_r <= target_s;
                            end
                        end else if (!stall) begin
                            pc_r    <= pc_r + PC_STEP;
                            state_r <= ST_REQ;
                            req_r   <= 1'b1;
                        end else begin
                            hold_buf_r <= imem_rdata;
                            state_r    <= ST_HOLD;
                        end
                    end else if (redirect) begin
                        pc_r   <= target_s;
                        kill_r <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc_r    <= target_s;
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                    end else if (!stall) begin
                        pc_r    <= pc_r + PC_STEP;
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    kill_r  <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall, stall holds, else load or bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_valid_r <= 1'b0;
            ifid_pc_r    <= {PC_W{1'b0}};
            ifid_instr_r <= NOP;
        end else if (redirect) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP;
        end else if (stall) begin
            ifid_valid_r <= ifid_valid_r;
        end else if (deliver_s) begin
            ifid_valid_r <= 1'b1;
            ifid_pc_r    <= pc_r;
            ifid_instr_r <= deliver_instr_s;
        end else begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A behavioural instruction memory
//   answers each request after a programmable latency; every response the
//   bench expects to reach decode is pushed onto a scoreboard and popped when
//   a new instruction appears in IF/ID.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          PC_W  = 9;
    localparam int          INS_W = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_rvalid;
    logic [INS_W-1:0]  imem_rdata;
    logic              ifid_valid;
    logic [PC_W-1:0]   ifid_pc;
    logic [INS_W-1:0]  ifid_instr;
    logic [6:0]        ifid_opcode;

    fetch_stage #(.PC_W(PC_W), .INS_W(INS_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr),
        .ifid_opcode (ifid_opcode)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int              n_cmp = 0;
    int              n_err = 0;
    int              lat;
    bit              pend;
    int              cnt;
    bit              drop;
    bit              stall_on_rv;
    logic [PC_W-1:0] exp_pc;
    logic [PC_W-1:0] exp_req_pc;
    logic [PC_W-1:0] paddr;
    logic [40:0]     sb[$];
    int              ndel;
    int              nreq;
    bit              prev_valid;
    logic [PC_W-1:0] prev_pc;
    logic [31:0]     prev_instr;

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        case (a)
            9'h000:  return 32'h0050_0093;
            9'h004:  return 32'h00A0_0113;
            9'h008:  return 32'h0000_A283;
            default: return {14'h2A5, a, 2'b00, 7'h33};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe IF/ID against the scoreboard, then run the memory model.
    task automatic tick();
        logic [40:0] e;
        @(posedge clk);
        #1;
        if (ifid_valid === 1'b1 &&
            (!prev_valid || ifid_pc !== prev_pc || ifid_instr !== prev_instr)) begin
            ndel++;
            if (sb.size() == 0) begin
                chk("ifid_extra", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("ifid_pc", 64'(ifid_pc), 64'(e[40:32]));
                chk("ifid_instr", 64'(ifid_instr), 64'(e[31:0]));
                chk("ifid_opcode", 64'(ifid_opcode), 64'(e[6:0]));
            end
        end
        prev_valid = (ifid_valid === 1'b1);
        prev_pc    = ifid_pc;
        prev_instr = ifid_instr;

        imem_rvalid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                pend        = 1'b0;
                if (stall_on_rv) begin
                    stall       = 1'b1;
                    stall_on_rv = 1'b0;
                end
                if (!drop) begin
                    chk("addr_stable", 64'(imem_addr), 64'(exp_req_pc));
                    sb.push_back({exp_req_pc, mem_word(exp_req_pc)});
                    exp_pc = exp_req_pc + 9'd4;
                end else begin
                    drop = 1'b0;
                end
            end
        end
        if (imem_req === 1'b1) begin
            nreq++;
            chk("one_outstanding", 64'(pend), 64'd0);
            chk("req_addr", 64'(imem_addr), 64'(exp_pc));
            exp_req_pc = exp_pc;
            paddr      = imem_addr;
            pend       = 1'b1;
            cnt        = lat;
        end
    endtask

    task automatic wait_del(input int target);
        for (int i = 0; i < 60 && ndel < target; i++) tick();
        chk("deliver_in_time", 64'(ndel >= target), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},  64'(ifid_valid),  64'd0);
        chk({tag, "_pc"},     64'(ifid_pc),     64'd0);
        chk({tag, "_instr"},  64'(ifid_instr),  64'(NOP));
        chk({tag, "_opcode"}, 64'(ifid_opcode), 64'h13);
        chk({tag, "_req"},    64'(imem_req),    64'd0);
        chk({tag, "_addr"},   64'(imem_addr),   64'd0);
    endtask

    // Directed scenarios; IF/ID contents are checked through the scoreboard.
    initial begin
        int exp_v[5];
        int r0;
        int d0;
        exp_v = '{0, 0, 1, 0, 1};
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 9'h000;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        lat = 1; pend = 1'b0; cnt = 0; drop = 1'b0; stall_on_rv = 1'b0;
        exp_pc = 9'h000; exp_req_pc = 9'h000; paddr = 9'h000;
        ndel = 0; nreq = 0; prev_valid = 1'b0; prev_pc = 9'h000; prev_instr = 32'h0;

        tick(); tick();
        chk_reset_outputs("rst");

        // Latency-1 fetch of 0x000 and 0x004: valid on cycles 3 and 5.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("valid_cyc%0d", i + 1), 64'(ifid_valid), 64'(exp_v[i]));
            if (i == 0) chk("req_cyc1", 64'(imem_req), 64'd1);
        end

        // Stall raised in the cycle the word for 0x008 returns.
        stall_on_rv = 1'b1;
        for (int i = 0; i < 10 && stall !== 1'b1; i++) tick();
        chk("hold_entry_addr", 64'(imem_addr), 64'h008);
        tick();
        chk("hold_valid", 64'(ifid_valid), 64'd0);
        chk("hold_pc",    64'(ifid_pc),    64'h004);
        chk("hold_instr", 64'(ifid_instr), 64'(NOP));
        chk("hold_req",   64'(imem_req),   64'd0);
        tick();
        chk("hold_addr",  64'(imem_addr),  64'h008);
        chk("hold_req2",  64'(imem_req),   64'd0);
        lat = 3;
        stall = 1'b0;
        wait_del(ndel + 1);
        chk("next_addr_c", 64'(imem_addr), 64'h00C);

        // Latency 3: one request per fetch.
        r0 = nreq; d0 = ndel;
        wait_del(d0 + 2);
        chk("req_per_fetch", 64'(nreq - r0), 64'(ndel - d0));

        // Redirect to 0x043 while waiting: reply dropped, refetch at 0x040.
        tick();
        chk("t5_in_wait", 64'(imem_req), 64'd0);
        redirect = 1'b1; redirect_pc = 9'h043; drop = 1'b1; exp_pc = 9'h040;
        tick();
        redirect = 1'b0;
        chk("t5_flush_valid", 64'(ifid_valid), 64'd0);
        wait_del(ndel + 1);
        chk("t5_pc", 64'(ifid_pc), 64'h040);

        // Redirect and stall together with a valid IF/ID: flush wins.
        chk("t6_pre_valid", 64'(ifid_valid), 64'd1);
        redirect = 1'b1; stall = 1'b1; redirect_pc = 9'h100; drop = 1'b1; exp_pc = 9'h100;
        tick();
        redirect = 1'b0; stall = 1'b0;
        chk("t6_valid",  64'(ifid_valid),  64'd0);
        chk("t6_instr",  64'(ifid_instr),  64'(NOP));
        chk("t6_opcode", 64'(ifid_opcode), 64'h13);
        wait_del(ndel + 1);

        // PC wrap: fetch at 0x1FC, next request at 0x000.
        redirect = 1'b1; redirect_pc = 9'h1FE; drop = 1'b1; exp_pc = 9'h1FC;
        tick();
        redirect = 1'b0;
        wait_del(ndel + 1);
        chk("wrap_pc",   64'(ifid_pc),   64'h1FC);
        chk("wrap_addr", 64'(imem_addr), 64'h000);

        // Asynchronous reset in the middle of a wait.
        tick();
        chk("t8_in_wait", 64'(imem_req), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        pend = 1'b0; drop = 1'b0; imem_rvalid = 1'b0; prev_valid = 1'b0; exp_pc = 9'h000;
        #1;
        reset = 1'b1;
        wait_del(ndel + 1);
        chk("post_reset_pc", 64'(ifid_pc), 64'h000);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the opcode decoder. It feeds the decoder and the rest of decode through an IF/ID pipeline register.
- Owns the PC register and issues one outstanding request at a time to a variable-latency instruction memory.
- Absorbs a decode-side stall with a one-entry hold buffer.
- Redirects on taken branch/JAL and flushes wrong-path instructions.

Parameters:
- PC_W, 9: byte-address width of PC and instruction-memory address.
- INS_W, 32: instruction width.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- stall  input  1  hold IF/ID contents and do not advance PC (load-use hazard).
- redirect  input  1  taken branch/JAL from execute; flush and refetch.
- redirect_pc  input  PC_W  target byte address; bits [1:0] ignored.
- imem_req  output  1  one-cycle request strobe; memory always accepts.
- imem_addr  output  PC_W  request address; bits [1:0] always 0.
- imem_rvalid  input  1  response valid; arrives 1 or more cycles after imem_req.
- imem_rdata  input  INS_W  instruction word; qualified by imem_rvalid.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_pc  output  PC_W  PC of the instruction in IF/ID.
- ifid_instr  output  INS_W  instruction in IF/ID.
- ifid_opcode  output  7  ifid_instr[6:0]; drives the decoder Opcode input.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; state=IDLE; kill=0; hold_buf=0.
  - ifid_valid=0, ifid_pc=0, ifid_instr=32'h00000013 (NOP), ifid_opcode=7'h13.
  - imem_req=0, imem_addr=RESET_PC.
  - Reset mid-request: the in-flight response is lost; the memory is assumed reset on the same reset.
- imem_addr = {pc[PC_W-1:2], 2'b00} at all times. imem_req = 1 only in state REQ.
- IDLE:
  - One cycle after reset release, go to REQ.
  - redirect in IDLE: pc <= redirect_pc & ~3.
- REQ:
  - Assert imem_req; go to WAIT unconditionally.
  - redirect in REQ: pc <= redirect_pc & ~3; kill <= 1, so the just-issued response is dropped.
- WAIT (imem_req = 0):
  - No rvalid: stay. A redirect here sets pc <= redirect_pc & ~3 and kill <= 1.
  - rvalid with (kill or redirect): discard the data; kill <= 0; pc <= redirect_pc & ~3 if redirect; go to REQ.
  - rvalid, no kill/redirect, stall=0: ifid_pc <= pc; ifid_instr <= imem_rdata; ifid_valid <= 1; pc <= pc+4; go to REQ.
  - rvalid, no kill/redirect, stall=1: hold_buf <= imem_rdata; go to HOLD; pc unchanged.
- HOLD:
  - stall=0, no redirect: IF/ID <= {pc, hold_buf, valid=1}; pc <= pc+4; go to REQ.
  - redirect: drop hold_buf; pc <= redirect_pc & ~3; go to REQ.
- IF/ID update rules, in priority order:
  1. redirect=1: ifid_valid <= 0, ifid_instr <= NOP. Flush wins over stall.
  2. stall=1: hold all IF/ID fields.
  3. Instruction delivered this cycle: load IF/ID as above.
  4. Otherwise insert a bubble: ifid_valid <= 0, ifid_instr <= NOP, ifid_pc held.
- Arithmetic: pc+4 is modulo 2^PC_W and wraps to 0 with no flag.
- rvalid outside WAIT is illegal and ignored; no state change.
- Throughput: at most one instruction per 2 cycles (REQ then WAIT with 1-cycle latency). Latency from request to IF/ID valid = memory latency + 1 edge.

Test Plan:
- Reset release, memory latency 1, rdata = 0x00500093, 0x00A00113: IF/ID shows pc 0x000 valid on cycle 3 and pc 0x004 on cycle 5; ifid_opcode=0x13; ifid_valid=0 between them.
- Latency 3 cycles: imem_req pulses exactly once per fetch; no second request while WAIT; pc advances only on rvalid.
- stall=1 raised the cycle rvalid returns 0x0000A283 at pc 0x008: state HOLD, IF/ID unchanged. After stall drops, IF/ID = {0x008, 0x0000A283}, next imem_addr=0x00C.
- redirect with redirect_pc=0x043 while WAIT: response dropped, ifid_valid=0, next imem_addr=0x040, the fetched word lands with ifid_pc=0x040.
- redirect and stall asserted together with IF/ID valid: flush wins, ifid_valid=0, ifid_instr=0x00000013.
- PC_W=9, pc=0x1FC fetch completes: next imem_addr=0x000. Assert reset=0 mid-WAIT: all outputs return to their reset values immediately, without waiting for a clock edge.
